// File: rtl/ls193_count_driver_if.sv
`timescale 1ns/1ps
// ls193_count_driver_if: request/strobe bundle between the system side and the LS193 driver.
// Ports: requests i_inc/i_dec/i_ldreq/i_clrreq/i_data, counter feedback i_co/i_bo (async),
//   strobes o_up/o_down/o_load/o_clr, data o_a..o_d, status o_busy/o_ovf/o_wrap.
interface ls193_count_driver_if;
  logic       i_inc;
  logic       i_dec;
  logic       i_ldreq;
  logic       i_clrreq;
  logic [3:0] i_data;
  logic       i_co;
  logic       i_bo;
  logic       o_up;
  logic       o_down;
  logic       o_load;
  logic       o_clr;
  logic       o_a;
  logic       o_b;
  logic       o_c;
  logic       o_d;
  logic       o_busy;
  logic       o_ovf;
  logic       o_wrap;

  // master: system side / counter model driving requests and feedback
  modport master (
    output i_inc, i_dec, i_ldreq, i_clrreq, i_data, i_co, i_bo,
    input  o_up, o_down, o_load, o_clr, o_a, o_b, o_c, o_d, o_busy, o_ovf, o_wrap
  );

  // slave: the driver itself
  modport slave (
    input  i_inc, i_dec, i_ldreq, i_clrreq, i_data, i_co, i_bo,
    output o_up, o_down, o_load, o_clr, o_a, o_b, o_c, o_d, o_busy, o_ovf, o_wrap
  );
endinterface

// File: rtl/ls193_count_driver.sv
`timescale 1ns/1ps
// ls193_count_driver: turns single-cycle inc/dec/load/clear requests into LS193-legal pulses.
// Ports: i_clk, i_rst_n (async, active low), bus (slave modport of ls193_count_driver_if).
// Latency: inc at edge n -> o_up low from edge n+1 for LOW_CYC clocks; pulse period LOW+HIGH+1.
module ls193_count_driver #(
  parameter int LOW_CYC  = 2,
  parameter int HIGH_CYC = 2,
  parameter int CLR_CYC  = 2,
  parameter int PEND_W   = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  ls193_count_driver_if.slave  bus
);

  typedef enum logic [2:0] {
    S_CLEAR, S_IDLE, S_UP_LO, S_DN_LO, S_LOAD, S_RECOV
  } state_t;

  localparam int MAX_LH = (LOW_CYC > HIGH_CYC) ? LOW_CYC : HIGH_CYC;
  localparam int MAX_D  = (MAX_LH > CLR_CYC) ? MAX_LH : CLR_CYC;
  localparam int CW     = (MAX_D > 1) ? $clog2(MAX_D) : 1;
  // Two extra bits so pend + request - issued never wraps before clamping.
  localparam int PW     = PEND_W + 2;
  localparam logic signed [PW-1:0] P_HI  = PW'((2 ** PEND_W) - 1);
  localparam logic signed [PW-1:0] P_LO  = -P_HI;
  localparam logic signed [PW-1:0] ONE   = PW'(1);
  localparam logic signed [PW-1:0] M_ONE = {PW{1'b1}};

  state_t                  r_state, w_next;
  logic [CW-1:0]           r_cnt;
  logic signed [PEND_W:0]  r_pend;
  logic                    r_ld_pend, r_clr_pend;
  logic [3:0]              r_ld_dat, r_dat;
  logic                    r_up, r_down, r_load, r_clr, r_busy, r_ovf, r_wrap;
  logic                    r_co_s1, r_co_s2, r_bo_s1, r_bo_s2;

  logic                    w_enter_clr, w_enter_ld, w_up_done, w_dn_done, w_sat;
  logic                    w_pend_pos, w_pend_neg;
  logic signed [PW-1:0]    w_ext, w_req, w_iss, w_sum, w_clamped;

  assign w_pend_neg = r_pend[PEND_W];
  assign w_pend_pos = !r_pend[PEND_W] && (r_pend != '0);

  // Next-state logic; dwell counter counts clocks spent in the current state.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_CLEAR: if (r_cnt == CW'(CLR_CYC - 1)) w_next = S_RECOV;
      S_IDLE: begin
        if (r_clr_pend || bus.i_clrreq)     w_next = S_CLEAR;
        else if (r_ld_pend || bus.i_ldreq)  w_next = S_LOAD;
        else if (w_pend_pos)                w_next = S_UP_LO;
        else if (w_pend_neg)                w_next = S_DN_LO;
      end
      S_UP_LO, S_DN_LO, S_LOAD:
        if (r_cnt == CW'(LOW_CYC - 1)) w_next = S_RECOV;
      S_RECOV: if (r_cnt == CW'(HIGH_CYC - 1)) w_next = S_IDLE;
      default: w_next = S_CLEAR;
    endcase
  end

  assign w_enter_clr = (w_next == S_CLEAR) && (r_state != S_CLEAR);
  assign w_enter_ld  = (w_next == S_LOAD)  && (r_state != S_LOAD);
  assign w_up_done   = (r_state == S_UP_LO) && (w_next == S_RECOV);
  assign w_dn_done   = (r_state == S_DN_LO) && (w_next == S_RECOV);

  // Net pending count: requests in, completed pulses out, clamp at +/-P_HI.
  always_comb begin
    w_ext = {{(PW - PEND_W - 1){r_pend[PEND_W]}}, r_pend};
    w_req = '0;
    if (bus.i_inc && !bus.i_dec)      w_req = ONE;
    else if (bus.i_dec && !bus.i_inc) w_req = M_ONE;
    w_iss = '0;
    if (w_up_done)      w_iss = ONE;
    else if (w_dn_done) w_iss = M_ONE;
    w_sum     = w_ext + w_req - w_iss;
    w_sat     = (w_sum > P_HI) || (w_sum < P_LO);
    w_clamped = w_sum;
    if (w_sum > P_HI)      w_clamped = P_HI;
    else if (w_sum < P_LO) w_clamped = P_LO;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state || w_next == S_IDLE) r_cnt <= '0;
      else                                        r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend     <= '0;
      r_ld_pend  <= 1'b0;
      r_clr_pend <= 1'b0;
      r_ld_dat   <= '0;
      r_dat      <= '0;
      r_ovf      <= 1'b0;
    end else begin
      // Requests arriving while busy are parked until the next IDLE.
      if (r_state != S_IDLE) begin
        if (bus.i_ldreq) begin
          r_ld_pend <= 1'b1;
          r_ld_dat  <= bus.i_data;
        end
        if (bus.i_clrreq) r_clr_pend <= 1'b1;
      end
      if (w_enter_clr) begin
        r_pend     <= '0;
        r_ld_pend  <= 1'b0;
        r_clr_pend <= 1'b0;
        r_ovf      <= 1'b0;
      end else begin
        if (w_sat) r_ovf <= 1'b1;
        if (w_enter_ld) begin
          r_pend    <= '0;
          r_ld_pend <= 1'b0;
          // A fresh request in the same clock supersedes the parked data.
          r_dat     <= bus.i_ldreq ? bus.i_data : r_ld_dat;
        end else begin
          r_pend <= w_clamped[PEND_W:0];
        end
      end
    end
  end

  // Strobes registered from the next state so they are glitch-free at the counter pins.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_up   <= 1'b1;
      r_down <= 1'b1;
      r_load <= 1'b1;
      r_clr  <= 1'b1;
      r_busy <= 1'b1;
    end else begin
      r_up   <= (w_next != S_UP_LO);
      r_down <= (w_next != S_DN_LO);
      r_load <= (w_next != S_LOAD);
      r_clr  <= (w_next == S_CLEAR);
      r_busy <= (w_next != S_IDLE);
    end
  end

  // _CO/_BO synchronisers; a synced low sets the sticky wrap flag, which beats a clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_co_s1 <= 1'b1;
      r_co_s2 <= 1'b1;
      r_bo_s1 <= 1'b1;
      r_bo_s2 <= 1'b1;
      r_wrap  <= 1'b0;
    end else begin
      r_co_s1 <= bus.i_co;
      r_co_s2 <= r_co_s1;
      r_bo_s1 <= bus.i_bo;
      r_bo_s2 <= r_bo_s1;
      if (!r_co_s2 || !r_bo_s2) r_wrap <= 1'b1;
      else if (w_enter_clr)     r_wrap <= 1'b0;
    end
  end

  assign bus.o_up   = r_up;
  assign bus.o_down = r_down;
  assign bus.o_load = r_load;
  assign bus.o_clr  = r_clr;
  assign bus.o_a    = r_dat[0];
  assign bus.o_b    = r_dat[1];
  assign bus.o_c    = r_dat[2];
  assign bus.o_d    = r_dat[3];
  assign bus.o_busy = r_busy;
  assign bus.o_ovf  = r_ovf;
  assign bus.o_wrap = r_wrap;

endmodule
